// File: rtl/proj_sel_pkg.sv
// Shared types and register map for the project select controller.
// Holds the switch FSM state encoding, register byte offsets and bit-field positions.
package proj_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DROP = 2'd1,
    ST_GAP  = 2'd2,
    ST_ARM  = 2'd3
  } state_t;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned GAP_W = 8;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_GAP    = 4'h8;
  localparam logic [3:0] OFF_IRQ    = 4'hC;

  localparam int unsigned CTRL_EN_BIT  = 8;
  localparam int unsigned ST_VALID_BIT = 8;
  localparam int unsigned ST_BUSY_BIT  = 9;
  localparam int unsigned ST_ERR_BIT   = 10;
  localparam int unsigned ST_STATE_LSB = 16;
  localparam int unsigned IRQ_DONE_BIT = 0;
  localparam int unsigned IRQ_EN_BIT   = 1;

endpackage

// File: rtl/proj_sel_wb_regs.sv
// Wishbone slave decode, single-cycle ack and the register file (CTRL, STATUS, GAP, IRQ).
// Ports: i_clk/i_rst_n clock and async active-low reset; i_stb..i_adr Wishbone request;
//        i_state/i_cur/i_cur_valid FSM status in; i_take consumes the pending request;
//        i_done_set flags switch done; o_ack/o_dat Wishbone response; o_ctrl_*/o_pending/
//        o_gap request and gap to the FSM; o_irq level interrupt.
module proj_sel_wb_regs
  import proj_sel_pkg::*;
#(
  parameter int unsigned NUM_PROJ  = 5,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [7:0]  GAP_RESET = 8'd16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stb,
  input  logic             i_cyc,
  input  logic             i_we,
  input  logic [3:0]       i_sel,
  input  logic [31:0]      i_dat,
  input  logic [31:0]      i_adr,
  input  logic [1:0]       i_state,
  input  logic [SEL_W-1:0] i_cur,
  input  logic             i_cur_valid,
  input  logic             i_take,
  input  logic             i_done_set,
  output logic             o_ack,
  output logic [31:0]      o_dat,
  output logic [SEL_W-1:0] o_ctrl_sel,
  output logic             o_ctrl_en,
  output logic             o_pending,
  output logic [GAP_W-1:0] o_gap,
  output logic             o_irq
);

  logic             r_ack, r_en, r_pending, r_err, r_done, r_irq_en, r_irq;
  logic [31:0]      r_dat;
  logic [SEL_W-1:0] r_sel;
  logic [GAP_W-1:0] r_gap;

  logic             w_hit, w_acc, w_wr_ctrl, w_wr_gap, w_wr_irq, w_w1c, w_busy;
  logic             w_en_nxt, w_irq_en_nxt, w_done_nxt, w_sel_bad;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Accept only when not already acking, so a held strobe cannot re-trigger.
  assign w_hit     = i_stb & i_cyc & (i_adr[31:4] == BASE_ADDR[31:4]);
  assign w_acc     = w_hit & ~r_ack;
  assign w_wr_ctrl = w_acc & i_we & (i_adr[3:0] == OFF_CTRL);
  assign w_wr_gap  = w_acc & i_we & (i_adr[3:0] == OFF_GAP);
  assign w_wr_irq  = w_acc & i_we & (i_adr[3:0] == OFF_IRQ);
  assign w_busy    = (i_state != ST_IDLE) | r_pending;
  assign w_unused  = ^{i_dat[31:9], i_sel[3:2]};

  // Byte-lane merge of register writes.
  always_comb begin
    w_sel_nxt    = r_sel;
    w_en_nxt     = r_en;
    w_gap_nxt    = r_gap;
    w_irq_en_nxt = r_irq_en;
    w_w1c        = 1'b0;
    if (w_wr_ctrl && i_sel[0]) w_sel_nxt = i_dat[SEL_W-1:0];
    if (w_wr_ctrl && i_sel[1]) w_en_nxt  = i_dat[CTRL_EN_BIT];
    if (w_wr_gap && i_sel[0])  w_gap_nxt = i_dat[GAP_W-1:0];
    if (w_wr_irq && i_sel[0]) begin
      w_irq_en_nxt = i_dat[IRQ_EN_BIT];
      w_w1c        = i_dat[IRQ_DONE_BIT];
    end
  end

  // A new done event wins over a simultaneous write-1-to-clear.
  assign w_done_nxt = i_done_set | (r_done & ~w_w1c);
  assign w_sel_bad  = w_en_nxt & ({1'b0, w_sel_nxt} >= 4'(NUM_PROJ));

  // Read data mux; unmapped bits and offsets read zero.
  always_comb begin
    w_rdata = '0;
    case (i_adr[3:0])
      OFF_CTRL: begin
        w_rdata[SEL_W-1:0]   = r_sel;
        w_rdata[CTRL_EN_BIT] = r_en;
      end
      OFF_STATUS: begin
        w_rdata[SEL_W-1:0]          = i_cur;
        w_rdata[ST_VALID_BIT]       = i_cur_valid;
        w_rdata[ST_BUSY_BIT]        = w_busy;
        w_rdata[ST_ERR_BIT]         = r_err;
        w_rdata[ST_STATE_LSB +: 2]  = i_state;
      end
      OFF_GAP: w_rdata[GAP_W-1:0] = r_gap;
      OFF_IRQ: begin
        w_rdata[IRQ_DONE_BIT] = r_done;
        w_rdata[IRQ_EN_BIT]   = r_irq_en;
      end
      default: ;
    endcase
  end

  // Register state; a CTRL write in the same cycle as a take keeps the request pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_en      <= 1'b0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
      r_gap     <= GAP_RESET;
      r_done    <= 1'b0;
      r_irq_en  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_ack     <= w_acc;
      r_dat     <= (w_acc & ~i_we) ? w_rdata : '0;
      r_sel     <= w_sel_nxt;
      r_en      <= w_en_nxt;
      r_pending <= w_wr_ctrl | (r_pending & ~i_take);
      r_err     <= w_wr_ctrl ? w_sel_bad : r_err;
      r_gap     <= w_gap_nxt;
      r_done    <= w_done_nxt;
      r_irq_en  <= w_irq_en_nxt;
      r_irq     <= w_done_nxt & w_irq_en_nxt;
    end
  end

  assign o_ack      = r_ack;
  assign o_dat      = r_dat;
  assign o_ctrl_sel = r_sel;
  assign o_ctrl_en  = r_en;
  assign o_pending  = r_pending;
  assign o_gap      = r_gap;
  assign o_irq      = r_irq;

endmodule

// File: rtl/project_select_ctrl.sv
// Project select controller: break-before-make switching of one-hot project activation lines.
// Ports: wb_clk_i/wb_rst_ni clock and async active-low reset; wbs_* Wishbone slave;
//        active_o one-hot-or-zero activation lines; irq_o switch-done interrupt.
module project_select_ctrl
  import proj_sel_pkg::*;
#(
  parameter int unsigned NUM_PROJ  = 5,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [7:0]  GAP_RESET = 8'd16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_dat_i,
  input  logic [31:0]         wbs_adr_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic [NUM_PROJ-1:0] active_o,
  output logic                irq_o
);

  state_t              r_state, w_state_nxt;
  logic [GAP_W-1:0]    r_cnt, w_cnt_nxt;
  logic [NUM_PROJ-1:0] r_active, w_active_nxt;
  logic [SEL_W-1:0]    r_cur, w_cur_nxt, r_tgt_sel, w_tgt_sel_nxt;
  logic                r_cur_valid, w_cur_valid_nxt, r_tgt_en, w_tgt_en_nxt;

  logic [SEL_W-1:0]    w_ctrl_sel;
  logic [GAP_W-1:0]    w_gap;
  logic                w_ctrl_en, w_pending, w_take, w_done_set, w_req_en, w_same;

  proj_sel_wb_regs #(
    .NUM_PROJ  (NUM_PROJ),
    .BASE_ADDR (BASE_ADDR),
    .GAP_RESET (GAP_RESET)
  ) u_regs (
    .i_clk       (wb_clk_i),
    .i_rst_n     (wb_rst_ni),
    .i_stb       (wbs_stb_i),
    .i_cyc       (wbs_cyc_i),
    .i_we        (wbs_we_i),
    .i_sel       (wbs_sel_i),
    .i_dat       (wbs_dat_i),
    .i_adr       (wbs_adr_i),
    .i_state     (r_state),
    .i_cur       (r_cur),
    .i_cur_valid (r_cur_valid),
    .i_take      (w_take),
    .i_done_set  (w_done_set),
    .o_ack       (wbs_ack_o),
    .o_dat       (wbs_dat_o),
    .o_ctrl_sel  (w_ctrl_sel),
    .o_ctrl_en   (w_ctrl_en),
    .o_pending   (w_pending),
    .o_gap       (w_gap),
    .o_irq       (irq_o)
  );

  // An out-of-range selection is treated as a disable request.
  assign w_req_en = w_ctrl_en & ({1'b0, w_ctrl_sel} < 4'(NUM_PROJ));
  assign w_same   = (w_req_en == r_cur_valid) & (~w_req_en | (w_ctrl_sel == r_cur));

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next state and datapath updates; the target is frozen on leaving IDLE.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_active_nxt    = r_active;
    w_cur_nxt       = r_cur;
    w_cur_valid_nxt = r_cur_valid;
    w_tgt_sel_nxt   = r_tgt_sel;
    w_tgt_en_nxt    = r_tgt_en;
    w_take          = 1'b0;
    w_done_set      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          w_take = 1'b1;
          if (!w_same) begin
            w_state_nxt   = ST_DROP;
            w_tgt_sel_nxt = w_ctrl_sel;
            w_tgt_en_nxt  = w_req_en;
            w_active_nxt  = '0;
          end
        end
      end
      ST_DROP: begin
        w_cnt_nxt   = w_gap;
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_ARM;
          for (int i = 0; i < NUM_PROJ; i++) begin
            w_active_nxt[i] = r_tgt_en & (r_tgt_sel == SEL_W'(i));
          end
          w_cur_nxt       = r_tgt_en ? r_tgt_sel : '0;
          w_cur_valid_nxt = r_tgt_en;
        end else begin
          w_cnt_nxt = r_cnt - GAP_W'(1);
        end
      end
      ST_ARM: begin
        w_done_set  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers; reset clears the activation lines asynchronously.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cnt       <= '0;
      r_active    <= '0;
      r_cur       <= '0;
      r_cur_valid <= 1'b0;
      r_tgt_sel   <= '0;
      r_tgt_en    <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_active    <= w_active_nxt;
      r_cur       <= w_cur_nxt;
      r_cur_valid <= w_cur_valid_nxt;
      r_tgt_sel   <= w_tgt_sel_nxt;
      r_tgt_en    <= w_tgt_en_nxt;
    end
  end

  assign active_o = r_active;

endmodule

// File: tb/tb_project_select_ctrl.sv
// Directed self-checking bench for project_select_ctrl.
module tb_project_select_ctrl;

  localparam int unsigned NP   = 5;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stb, cyc, we;
  logic [3:0]    sel;
  logic [31:0]   dat_i, adr;
  logic          ack;
  logic [31:0]   dat_o;
  logic [NP-1:0] active;
  logic          irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  project_select_ctrl #(
    .NUM_PROJ  (NP),
    .BASE_ADDR (BASE),
    .GAP_RESET (8'd16)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .active_o  (active),
    .irq_o     (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] be);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE | {28'h0, off}; dat_i = d; sel = be;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("wr_ack", 32'(got), 32'd1);
  endtask

  task automatic wb_read(input logic [3:0] off, output logic [31:0] d);
    bit got;
    got = 1'b0;
    d   = '0;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | {28'h0, off}; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        d   = dat_o;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0;
    chk("rd_ack", 32'(got), 32'd1);
  endtask

  // Counts zero cycles of active until a new non-zero value appears.
  task automatic measure(output int zeros, output logic [NP-1:0] fin, output bit multi);
    zeros = 0; multi = 1'b0; fin = '0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if ($countones(active) > 1) multi = 1'b1;
      if (active == '0) zeros++;
      else if (zeros > 0) begin
        fin = active;
        break;
      end
    end
  endtask

  task automatic wait_nonzero(output logic [NP-1:0] fin);
    fin = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (active != '0) begin
        fin = active;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0]   rd;
    int            zeros;
    logic [NP-1:0] fin;
    bit            multi;

    rst_n = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; dat_i = '0; adr = '0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_ack",    32'(ack),    32'd0);
    chk("rst_dat",    dat_o,       32'd0);
    chk("rst_irq",    32'(irq),    32'd0);
    @(negedge clk); rst_n = 1'b1;

    wb_read(4'h4, rd); chk("rst_status", rd, 32'h0);
    wb_read(4'h0, rd); chk("rst_ctrl",   rd, 32'h0);
    wb_read(4'h8, rd); chk("rst_gap",    rd, 32'h10);
    wb_read(4'hC, rd); chk("rst_irqreg", rd, 32'h0);

    // First switch to project 2 with the default gap.
    wb_write(4'h0, 32'h102, 4'hF);
    measure(zeros, fin, multi);
    chk("sw2_zeros",  32'(zeros), 32'd18);
    chk("sw2_active", 32'(fin),   32'h04);
    chk("sw2_multi",  32'(multi), 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("sw2_irq_masked", 32'(irq), 32'd0);
    wb_read(4'h4, rd); chk("sw2_status", rd, 32'h102);
    wb_read(4'hC, rd); chk("sw2_done",   rd, 32'h1);

    // Unmapped CTRL bits read zero; identical config does not switch.
    wb_write(4'h0, 32'hFFFF_FF02, 4'hF);
    wb_read(4'h0, rd); chk("ctrl_mask", rd, 32'h102);

    // Switch 2 -> 4.
    chk("pre_sw4", 32'(active), 32'h04);
    wb_write(4'h0, 32'h104, 4'hF);
    measure(zeros, fin, multi);
    chk("sw4_zeros",  32'(zeros), 32'd18);
    chk("sw4_active", 32'(fin),   32'h10);
    chk("sw4_multi",  32'(multi), 32'd0);
    wb_write(4'hC, 32'h1, 4'hF);
    wb_read(4'hC, rd); chk("w1c_done", rd, 32'h0);

    // Out-of-range selection behaves as disable and flags err.
    wb_write(4'h0, 32'h107, 4'hF);
    repeat (25) @(posedge clk);
    #1 chk("bad_active", 32'(active), 32'd0);
    wb_read(4'h4, rd); chk("bad_status", rd, 32'h400);
    wb_read(4'hC, rd); chk("bad_done",   rd, 32'h1);

    // Zero gap still gives two dark cycles; interrupt enabled.
    wb_write(4'h8, 32'h0, 4'hF);
    wb_write(4'hC, 32'h3, 4'hF);
    chk("irq_cleared", 32'(irq), 32'd0);
    wb_write(4'h0, 32'h101, 4'hF);
    measure(zeros, fin, multi);
    chk("gap0_zeros",  32'(zeros), 32'd2);
    chk("gap0_active", 32'(fin),   32'h02);
    @(posedge clk); #1;
    chk("gap0_irq", 32'(irq), 32'd1);
    wb_read(4'h4, rd); chk("gap0_status", rd, 32'h101);
    wb_write(4'hC, 32'h3, 4'hF);
    chk("irq_w1c", 32'(irq), 32'd0);
    wb_read(4'hC, rd); chk("irq_reg", rd, 32'h2);

    // Same configuration is consumed without a switch or done.
    wb_write(4'h0, 32'h101, 4'hF);
    repeat (4) @(posedge clk);
    #1 chk("same_active", 32'(active), 32'h02);
    wb_read(4'h4, rd); chk("same_status", rd, 32'h101);
    wb_read(4'hC, rd); chk("same_done",   rd, 32'h2);
    chk("same_irq", 32'(irq), 32'd0);

    // Byte lane 1 only does not touch GAP.
    wb_write(4'h8, 32'hFF, 4'b0010);
    wb_read(4'h8, rd); chk("gap_bytesel", rd, 32'h0);
    wb_write(4'h8, 32'h10, 4'hF);
    wb_read(4'h8, rd); chk("gap_write", rd, 32'h10);

    // Writes during GAP are serviced after the in-flight switch.
    wb_write(4'h0, 32'h100, 4'hF);
    repeat (3) @(posedge clk);
    wb_write(4'h0, 32'h100, 4'hF);
    wb_write(4'h0, 32'h103, 4'hF);
    wait_nonzero(fin);
    chk("queue_first", 32'(fin), 32'h01);
    measure(zeros, fin, multi);
    chk("queue_zeros",  32'(zeros), 32'd18);
    chk("queue_second", 32'(fin),   32'h08);
    chk("queue_multi",  32'(multi), 32'd0);

    // Reset in the middle of GAP.
    wb_write(4'h0, 32'h100, 4'hF);
    repeat (3) @(posedge clk);
    wb_read(4'h4, rd); chk("gap_status", rd, 32'h0002_0303);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_active", 32'(active), 32'd0);
    chk("midrst_ack",    32'(ack),    32'd0);
    chk("midrst_dat",    dat_o,       32'd0);
    chk("midrst_irq",    32'(irq),    32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    wb_read(4'h4, rd); chk("postrst_status", rd, 32'h0);
    wb_read(4'h0, rd); chk("postrst_ctrl",   rd, 32'h0);
    wb_read(4'h8, rd); chk("postrst_gap",    rd, 32'h10);
    wb_read(4'hC, rd); chk("postrst_irqreg", rd, 32'h0);

    // Access just past the window gets no response.
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("miss_ack", 32'(ack), 32'd0);
      chk("miss_dat", dat_o,    32'd0);
    end
    stb = 1'b0; cyc = 1'b0;

    // Reset drops a lit activation line without waiting for a clock.
    wb_write(4'h0, 32'h103, 4'hF);
    wait_nonzero(fin);
    chk("lit_active", 32'(fin), 32'h08);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_active", 32'(active), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
